output_module: RTL and testbench
================================

OUTPUT_MODULE -- requirements
Module: output_module

Interface
REQ-001 SHALL have parameter MSB_SLOT, default 5, meaning log2 of flit width.
REQ-002 SHALL have parameter DSIZE, default 1<<MSB_SLOT, meaning flit width in bits.
REQ-003 SHALL have parameter PORT, default 3'b000, meaning the direction code this output drives (N=000, S=001, E=010, W=011, L=100).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port req, input, 5 bits: per-source non-empty flags from the VC buffers holding flits for this direction; bit order [L,W,E,S,N] = [4:0].
REQ-007 SHALL have port data_in, input, 5*DSIZE bits: source i data at [i*DSIZE +: DSIZE], valid the cycle after that source's read strobe.
REQ-008 SHALL have port grant, output, 5 bits: one-hot, one-cycle read strobe to the winning source VC buffer.
REQ-009 SHALL have port output_full, input, 1 bit: downstream FIFO full.
REQ-010 SHALL have port output_write, output, 1 bit: downstream FIFO write strobe.
REQ-011 SHALL have port data_out, output, DSIZE bits: registered flit presented to the downstream FIFO.
REQ-012 SHALL have port src_sel, output, 3 bits: direction code of the flit held in data_out; 3'b111 (INVALID) when none is held.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH and SEND.
REQ-014 SHALL mask req[PORT] before arbitration; a flit is never sent back out of its arrival direction.
REQ-015 In IDLE with any masked request set, SHALL drive grant one-hot to the round-robin winner and go to FETCH the next cycle; with no masked request, SHALL stay in IDLE with grant=0.
REQ-016 SHALL arbitrate round-robin: search starts at the pointer index ascending modulo 5; after a grant to index i, the pointer SHALL become (i+1) mod 5.
REQ-017 In FETCH, SHALL register data_in slot of the granted index into data_out, set src_sel to that index, and go to SEND; grant SHALL be 0.
REQ-018 In SEND, SHALL drive output_write = !output_full combinationally; data_out and src_sel SHALL stay stable while output_full=1.
REQ-019 In SEND with output_full=0 and a masked request set, SHALL issue the next grant in the same cycle and go to FETCH.
REQ-020 In SEND with output_full=0 and no masked request, SHALL go to IDLE and set src_sel to INVALID.
REQ-021 SHALL never assert grant in SEND while output_full=1.
REQ-022 Sustained throughput SHALL be one flit per two cycles; grant-to-output_write latency SHALL be 2 cycles when output_full=0.
REQ-023 A request deasserting after its grant SHALL NOT cancel the FETCH; the flit is captured regardless.
REQ-024 At most one grant bit and at most one output_write SHALL be high in any cycle.

Reset
REQ-025 With reset=0 at a clock edge, SHALL enter IDLE, set pointer=0 (N), grant=0, output_write=0, data_out=0 and src_sel=3'b111.
REQ-026 Reset asserted in FETCH or SEND SHALL discard the in-flight flit without writing it downstream.

Structure
REQ-027 Direction codes (N, S, E, W, L, INVALID), FSM state encodings and the default MSB_SLOT/DSIZE SHALL live in shared package noc_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (5 requests in, registered pointer, one-hot grant and 3-bit index out).

Verification
REQ-029 PORT=N, req=5'b00010, data_in S slot=32'hA5A5_0001, output_full=0 -> grant=5'b00010 at t, output_write=1 with data_out=32'hA5A5_0001 and src_sel=001 at t+2.
REQ-030 PORT=N, req=5'b00001 held -> grant stays 0, output_write never asserted (U-turn mask).
REQ-031 PORT=L, req=5'b01111 held, output_full=0 -> grant sequence N,S,E,W,N at 2-cycle spacing.
REQ-032 Flit in SEND, output_full=1 for 4 cycles -> output_write=0, data_out and src_sel unchanged, grant=0; output_full=0 -> output_write=1 for exactly one cycle.
REQ-033 reset=0 in FETCH -> next cycle IDLE, data_out=0, src_sel=111, no output_write; req=5'b01000 afterwards -> W granted first.
REQ-034 req=5'b00100 pulsed for one cycle in IDLE -> flit from E delivered once; no second grant.

Source files
------------

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg -- shared definitions for the router output stage.
//   * default flit sizing (MSB_SLOT_DEF / DSIZE_DEF)
//   * direction codes N/S/E/W/L plus INVALID (no flit held)
//   * output FSM state encodings
//   * dir_mask(): request mask that blocks the U-turn direction
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int MSB_SLOT_DEF = 5;
  localparam int DSIZE_DEF    = 1 << MSB_SLOT_DEF;
  localparam int NUM_SRC      = 5;

  typedef enum logic [2:0] {
    DIR_N       = 3'b000,
    DIR_S       = 3'b001,
    DIR_E       = 3'b010,
    DIR_W       = 3'b011,
    DIR_L       = 3'b100,
    DIR_INVALID = 3'b111
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_SEND  = 2'b10
  } state_e;

  // All-ones except the bit of the direction this output drives, so a flit
  // can never leave through the port it arrived on. Codes above L mask nothing.
  function automatic logic [NUM_SRC-1:0] dir_mask(input logic [2:0] port);
    logic [NUM_SRC-1:0] m;
    m = '1;
    if (port < 3'(NUM_SRC)) m[port] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- 5-way round-robin arbiter with a registered priority pointer.
// The search starts at the pointer and walks upward modulo 5; when the
// owner accepts the winner (advance=1) the pointer moves to winner+1.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous, active-low; pointer returns to N (0)
//   req      : request vector [L,W,E,S,N]
//   advance  : winner was consumed this cycle -> move the pointer
//   grant    : one-hot winner (combinational, 0 when no request)
//   idx      : binary index of the winner
//   valid    : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import noc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] grant,
  output logic [2:0]         idx,
  output logic               valid
);

  logic [2:0] ptr;
  int         cand;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (int'(ptr) + k) % NUM_SRC;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = 3'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (idx == 3'(NUM_SRC - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/output_module.sv
// ---------------------------------------------------------------------------
// output_module -- one router output port. Arbitrates among the five input
// VC buffers that hold flits for this direction, reads the winner, registers
// the flit and writes it to the downstream FIFO.
//
// Flow: IDLE --grant--> FETCH (capture data_in slot) --> SEND (write while
// downstream not full). A grant can be issued from SEND in the same cycle
// the current flit is written, giving one flit every two cycles.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-low
//   req          : per-source non-empty flags [L,W,E,S,N]
//   data_in      : source i flit at [i*DSIZE +: DSIZE], valid the cycle
//                  after that source's grant
//   grant        : one-hot one-cycle read strobe to the winning source
//   output_full  : downstream FIFO full
//   output_write : downstream FIFO write strobe
//   data_out     : registered flit presented downstream
//   src_sel      : direction code of the held flit, 3'b111 when none
// ---------------------------------------------------------------------------
module output_module
  import noc_pkg::*;
#(
  parameter int         MSB_SLOT = MSB_SLOT_DEF,
  parameter int         DSIZE    = (MSB_SLOT == MSB_SLOT_DEF) ? DSIZE_DEF : (1 << MSB_SLOT),
  parameter logic [2:0] PORT     = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*DSIZE-1:0] data_in,
  output logic [NUM_SRC-1:0]       grant,
  input  logic                     output_full,
  output logic                     output_write,
  output logic [DSIZE-1:0]         data_out,
  output logic [2:0]               src_sel
);

  state_e             state, state_next;
  logic [NUM_SRC-1:0] masked_req;
  logic [NUM_SRC-1:0] arb_grant;
  logic [2:0]         arb_idx;
  logic               arb_valid;
  logic               issue;
  logic [2:0]         fetch_idx;

  assign masked_req = req & dir_mask(PORT);

  rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (masked_req),
    .advance (issue),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    output_write = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          issue      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_SEND;
      end
      ST_SEND: begin
        // While downstream is full nothing moves: no write, no new grant.
        if (!output_full) begin
          output_write = 1'b1;
          if (arb_valid) begin
            issue      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A held reset must not read a source buffer or push the in-flight flit
    // downstream; the flit is simply dropped.
    if (!reset) begin
      issue        = 1'b0;
      output_write = 1'b0;
    end
  end

  assign grant = issue ? arb_grant : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    if (!reset) begin
      // NOTE: the data path is reset as well because data_out=0 and
      // src_sel=INVALID are visible downstream straight after reset.
      state     <= ST_IDLE;
      fetch_idx <= '0;
      data_out  <= '0;
      src_sel   <= DIR_INVALID;
    end else begin
      state <= state_next;
      if (issue) fetch_idx <= arb_idx;
      if (state == ST_FETCH) begin
        data_out <= data_in[int'(fetch_idx)*DSIZE +: DSIZE];
        src_sel  <= fetch_idx;
      end else if (state == ST_SEND && !output_full && !arb_valid) begin
        src_sel <= DIR_INVALID;
      end
    end
  end

endmodule

// File: tb/tb_output_module.sv
// ---------------------------------------------------------------------------
// tb_output_module -- drives two output_module instances (PORT=N, PORT=L)
// from shared stimulus; one instance at a time is selected for checking.
// A transaction-level model (flit age since grant, round-robin pointer as a
// plain integer) predicts grant, write, data and source each cycle.
// ---------------------------------------------------------------------------
module tb_output_module;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    req;
  logic [5*DW-1:0] data_in;
  logic          full;

  logic [4:0]    g_n, g_l, g;
  logic          ow_n, ow_l, ow;
  logic [DW-1:0] do_n, do_l, dout;
  logic [2:0]    ss_n, ss_l, ss;
  bit            sel;

  always #5 clk = ~clk;

  output_module #(.MSB_SLOT(5), .DSIZE(DW), .PORT(3'b000)) dut_n (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(g_n),
    .output_full(full), .output_write(ow_n), .data_out(do_n), .src_sel(ss_n));

  output_module #(.MSB_SLOT(5), .DSIZE(DW), .PORT(3'b100)) dut_l (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(g_l),
    .output_full(full), .output_write(ow_l), .data_out(do_l), .src_sel(ss_l));

  assign g    = sel ? g_l  : g_n;
  assign ow   = sel ? ow_l : ow_n;
  assign dout = sel ? do_l : do_n;
  assign ss   = sel ? ss_l : ss_n;

  int total = 0;
  int bad   = 0;

  // Source buffers (auto mode) and fixed per-source flits (manual mode).
  logic [DW-1:0] vcq [5][$];
  logic [DW-1:0] src_data [5] = '{32'hC0DE_0000, 32'hA5A5_0001, 32'hC0DE_0002,
                                  32'hC0DE_0003, 32'hC0DE_0004};
  bit auto_mode = 0;

  // Reference model state.
  int            m_port = 0;
  int            m_ptr  = 0;
  bit            m_has  = 0;
  int            m_age  = 0;
  int            m_src  = 0;
  logic [DW-1:0] m_data = '0;
  int            m_writes = 0;

  // Observation log.
  int            cyc = 0;
  int            g_count = 0, w_count = 0;
  logic [4:0]    last_grant = '0;
  int            last_grant_cyc = 0, last_write_cyc = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [2:0]    last_wsrc = '0;
  logic [4:0]    glog [$];
  int            gcyc [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] peek(input int i);
    if (!auto_mode) return src_data[i];
    if (vcq[i].size() != 0) return vcq[i][0];
    return '0;
  endfunction

  task automatic set_manual_data();
    for (int i = 0; i < 5; i++) data_in[i*DW +: DW] = src_data[i];
  endtask

  task automatic refresh_req();
    for (int i = 0; i < 5; i++) req[i] = (vcq[i].size() != 0);
  endtask

  // One clock: check outputs at negedge, advance model, react as the source
  // buffers would, then apply new inputs 1 time unit after the rising edge.
  task automatic cycle();
    logic [4:0]    mreq, eg;
    logic          ew, may_grant;
    int            win, c, popped;
    logic [DW-1:0] pflit;
    @(negedge clk);
    mreq = req;
    if (m_port < 5) mreq[m_port] = 1'b0;
    may_grant = reset && (!m_has || (m_age >= 2 && !full));
    win = -1;
    if (may_grant)
      for (int k = 0; k < 5; k++) begin
        c = (m_ptr + k) % 5;
        if (win < 0 && mreq[c]) win = c;
      end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    ew = reset && m_has && (m_age >= 2) && !full;

    check("grant", 64'(g), 64'(eg));
    check("output_write", 64'(ow), 64'(ew));
    check("grant_onehot", 64'($onehot0(g)), 64'd1);
    if (m_has && m_age >= 2) begin
      check("data_out", 64'(dout), 64'(m_data));
      check("src_sel", 64'(ss), 64'(m_src));
    end else if (!m_has) begin
      check("src_sel_idle", 64'(ss), 64'h7);
    end

    if (g != 0) begin
      g_count++; last_grant = g; last_grant_cyc = cyc;
      glog.push_back(g); gcyc.push_back(cyc);
    end
    if (ow) begin
      w_count++; last_write_cyc = cyc; last_wdata = dout; last_wsrc = ss;
    end
    popped = -1;
    for (int i = 0; i < 5; i++) if (g[i] && popped < 0) popped = i;

    if (!reset) begin
      m_has = 0; m_ptr = 0;
    end else begin
      if (ew) begin m_has = 0; m_writes++; end
      else if (m_has) m_age++;
      if (win >= 0) begin
        m_has = 1; m_age = 1; m_src = win; m_data = peek(win); m_ptr = (win + 1) % 5;
      end
    end

    pflit = '0;
    if (popped >= 0 && auto_mode && vcq[popped].size() != 0) pflit = vcq[popped].pop_front();

    @(posedge clk);
    cyc++;
    #1;
    if (auto_mode) begin
      for (int i = 0; i < 5; i++) data_in[i*DW +: DW] = $urandom;
      if (popped >= 0) data_in[popped*DW +: DW] = pflit;
      refresh_req();
    end
  endtask

  task automatic do_reset(input bit s, input int port);
    sel = s; m_port = port;
    reset = 1'b0; req = '0; full = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
  endtask

  function automatic bit busy();
    bit b;
    b = m_has;
    for (int i = 0; i < 5; i++) if (vcq[i].size() != 0) b = 1;
    return b;
  endfunction

  task automatic run_random(input bit s, input int port, input int n);
    int k;
    auto_mode = 1;
    for (int i = 0; i < 5; i++) vcq[i].delete();
    do_reset(s, port);
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 3) == 0 && vcq[i].size() < 4) vcq[i].push_back($urandom);
      refresh_req();
      full  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 79) != 0);
      cycle();
    end
    reset = 1'b1; full = 1'b0;
    vcq[port].delete();
    refresh_req();
    k = 0;
    while (busy() && k < 200) begin cycle(); k++; end
    check("drain_done", 64'(busy()), 64'd0);
  endtask

  initial begin
    int w0, g0, s_cyc;
    reset = 1'b0; req = '0; full = 1'b0; data_in = '0;
    set_manual_data();

    // Reset state, PORT=N instance.
    do_reset(1'b0, 0);
    @(negedge clk);
    check("rst_data_out", 64'(dout), 64'd0);
    check("rst_src_sel", 64'(ss), 64'h7);
    check("rst_grant", 64'(g), 64'd0);
    check("rst_write", 64'(ow), 64'd0);
    @(posedge clk); #1;

    // Single S flit, 2-cycle grant-to-write latency.
    req = 5'b00010; cycle();
    req = 5'b00000; repeat (4) cycle();
    check("s_latency", 64'(last_write_cyc - last_grant_cyc), 64'd2);
    check("s_data", 64'(last_wdata), 64'hA5A5_0001);
    check("s_src", 64'(last_wsrc), 64'd1);

    // U-turn: N request on the N output is ignored.
    g0 = g_count; w0 = w_count;
    req = 5'b00001; repeat (8) cycle();
    check("uturn_grants", 64'(g_count - g0), 64'd0);
    check("uturn_writes", 64'(w_count - w0), 64'd0);

    // One-cycle E pulse: delivered exactly once.
    g0 = g_count; w0 = w_count;
    req = 5'b00100; cycle();
    req = 5'b00000; repeat (6) cycle();
    check("pulse_grants", 64'(g_count - g0), 64'd1);
    check("pulse_writes", 64'(w_count - w0), 64'd1);
    check("pulse_data", 64'(last_wdata), 64'hC0DE_0002);

    // Backpressure: SEND held 4 cycles, E waits, released together.
    req = 5'b00010; cycle();
    req = 5'b00000; cycle();
    w0 = w_count; g0 = g_count;
    full = 1'b1; req = 5'b00100; repeat (4) cycle();
    check("stall_writes", 64'(w_count - w0), 64'd0);
    check("stall_grants", 64'(g_count - g0), 64'd0);
    full = 1'b0; cycle();
    req = 5'b00000;
    s_cyc = last_write_cyc;
    check("release_writes", 64'(w_count - w0), 64'd1);
    check("release_src", 64'(last_wsrc), 64'd1);
    check("release_grant", 64'(last_grant), 64'b00100);
    check("release_grant_cyc", 64'(last_grant_cyc), 64'(s_cyc));
    repeat (4) cycle();
    check("after_release_src", 64'(last_wsrc), 64'd2);

    // Reset during FETCH drops the flit; pointer back to N.
    w0 = w_count;
    req = 5'b00100; cycle();
    req = 5'b00000; reset = 1'b0; cycle();
    reset = 1'b1;
    @(negedge clk);
    check("fetch_rst_data", 64'(dout), 64'd0);
    check("fetch_rst_src", 64'(ss), 64'h7);
    @(posedge clk); #1;
    req = 5'b01000; cycle();
    check("post_rst_grant", 64'(last_grant), 64'b01000);
    req = 5'b00000; repeat (4) cycle();
    check("post_rst_writes", 64'(w_count - w0), 64'd1);
    check("post_rst_src", 64'(last_wsrc), 64'd3);

    // Round robin on the L output: N,S,E,W,N at 2-cycle spacing.
    do_reset(1'b1, 4);
    glog.delete(); gcyc.delete();
    req = 5'b01111; repeat (10) cycle();
    req = 5'b00000; repeat (3) cycle();
    check("rr_count", 64'(glog.size() >= 5), 64'd1);
    if (glog.size() >= 5) begin
      check("rr_0", 64'(glog[0]), 64'b00001);
      check("rr_1", 64'(glog[1]), 64'b00010);
      check("rr_2", 64'(glog[2]), 64'b00100);
      check("rr_3", 64'(glog[3]), 64'b01000);
      check("rr_4", 64'(glog[4]), 64'b00001);
      for (int i = 0; i < 4; i++) check("rr_spacing", 64'(gcyc[i+1] - gcyc[i]), 64'd2);
    end

    // Randomized traffic on both instances.
    run_random(1'b1, 4, 400);
    run_random(1'b0, 0, 400);
    check("write_count", 64'(w_count), 64'(m_writes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
